// File: rtl/lcd_pkg.sv
// Shared definitions for the memory-LCD command sequencer: opcodes and FSM states.
package lcd_pkg;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_WRITE_LINE = 8'h01;
  localparam logic [7:0] OP_CLEAR      = 8'h02;
  localparam logic [7:0] OP_DISP_ON    = 8'h03;
  localparam logic [7:0] OP_DISP_OFF   = 8'h04;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    LINE_ADDR = 3'd2,
    LINE_DATA = 3'd3,
    DISCARD   = 3'd4
  } state_t;

endpackage

// File: rtl/lcd_cmd_ctrl_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_r;
  logic sync_r;

  // metastability filter chain
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= i_d;
      sync_r <= meta_r;
    end
  end

  assign o_q = sync_r;

endmodule

// File: rtl/lcd_cmd_ctrl.sv
// Packet framer and command decoder feeding the frame buffer and the memory-LCD line engine.
module lcd_cmd_ctrl
  import lcd_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 128,
  parameter int FB_AW      = $clog2(LINE_BYTES * NUM_LINES),
  parameter int LINE_AW    = $clog2(NUM_LINES)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_dataValid,
  input  logic               i_spi_cs_n,
  output logic               o_fb_we,
  output logic [FB_AW-1:0]   o_fb_addr,
  output logic [7:0]         o_fb_data,
  output logic               o_upd_valid,
  output logic [LINE_AW-1:0] o_upd_line,
  input  logic               i_upd_ready,
  output logic               o_clr_req,
  input  logic               i_clr_ack,
  output logic               o_disp_en,
  output logic               o_err_cmd,
  output logic               o_err_ovr,
  input  logic               i_err_clr
);

  localparam int IDX_AW = $clog2(LINE_BYTES);

  state_t               state_r, state_nxt, dec_state_s;
  logic [LINE_AW-1:0]   line_r, line_nxt;
  logic [IDX_AW-1:0]    idx_r, idx_nxt;
  logic                 fb_we_r, fb_we_nxt;
  logic [FB_AW-1:0]     fb_addr_r, fb_addr_nxt;
  logic [7:0]           fb_data_r, fb_data_nxt;
  logic                 upd_valid_r;
  logic [LINE_AW-1:0]   upd_line_r;
  logic                 clr_req_r, disp_en_r, err_cmd_r, err_ovr_r;
  logic                 cs_sync_s, cs_prev_r, cs_fall_s, cs_rise_s;
  logic                 line_done_s, clr_set_s, disp_on_s, disp_off_s, cmd_err_s;

  sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_spi_cs_n),
    .o_q     (cs_sync_s)
  );

  assign cs_fall_s = cs_prev_r & ~cs_sync_s;
  assign cs_rise_s = ~cs_prev_r & cs_sync_s;

  // FSM, line/byte position and frame-buffer write register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= IDLE;
      cs_prev_r <= 1'b1;
      line_r    <= {LINE_AW{1'b0}};
      idx_r     <= {IDX_AW{1'b0}};
      fb_we_r   <= 1'b0;
      fb_addr_r <= {FB_AW{1'b0}};
      fb_data_r <= 8'h00;
    end else begin
      state_r   <= state_nxt;
      cs_prev_r <= cs_sync_s;
      line_r    <= line_nxt;
      idx_r     <= idx_nxt;
      fb_we_r   <= fb_we_nxt;
      fb_addr_r <= fb_addr_nxt;
      fb_data_r <= fb_data_nxt;
    end
  end

  // Byte decode; the current byte is always consumed before any framing edge takes effect
  always_comb begin
    dec_state_s = state_r;
    line_nxt    = line_r;
    idx_nxt     = idx_r;
    fb_we_nxt   = 1'b0;
    fb_addr_nxt = fb_addr_r;
    fb_data_nxt = fb_data_r;
    line_done_s = 1'b0;
    clr_set_s   = 1'b0;
    disp_on_s   = 1'b0;
    disp_off_s  = 1'b0;
    cmd_err_s   = 1'b0;
    if (i_rx_dataValid) begin
      case (state_r)
        CMD: begin
          case (i_rx_data)
            OP_NOP:        dec_state_s = CMD;
            OP_WRITE_LINE: dec_state_s = LINE_ADDR;
            OP_CLEAR:      clr_set_s   = 1'b1;
            OP_DISP_ON:    disp_on_s   = 1'b1;
            OP_DISP_OFF:   disp_off_s  = 1'b1;
            default: begin
              cmd_err_s   = 1'b1;
              dec_state_s = DISCARD;
            end
          endcase
        end
        LINE_ADDR: begin
          if ({1'b0, i_rx_data} < 9'(NUM_LINES)) begin
            line_nxt    = i_rx_data[LINE_AW-1:0];
            idx_nxt     = {IDX_AW{1'b0}};
            dec_state_s = LINE_DATA;
          end else begin
            cmd_err_s   = 1'b1;
            dec_state_s = DISCARD;
          end
        end
        LINE_DATA: begin
          fb_we_nxt   = 1'b1;
          fb_addr_nxt = FB_AW'({line_r, idx_r});
          fb_data_nxt = i_rx_data;
          if (idx_r == IDX_AW'(LINE_BYTES - 1)) begin
            line_done_s = 1'b1;
            idx_nxt     = {IDX_AW{1'b0}};
            if (line_r == LINE_AW'(NUM_LINES - 1)) begin
              line_nxt = {LINE_AW{1'b0}};
            end else begin
              line_nxt = line_r + LINE_AW'(1);
            end
          end else begin
            idx_nxt = idx_r + IDX_AW'(1);
          end
        end
        default: dec_state_s = state_r;
      endcase
    end else begin
      dec_state_s = state_r;
    end

    if (cs_fall_s) begin
      state_nxt = CMD;
    end else if (cs_rise_s) begin
      state_nxt = IDLE;
    end else begin
      state_nxt = dec_state_s;
    end
  end

  // Update/clear handshakes, display enable and sticky error flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      upd_valid_r <= 1'b0;
      upd_line_r  <= {LINE_AW{1'b0}};
      clr_req_r   <= 1'b0;
      disp_en_r   <= 1'b0;
      err_cmd_r   <= 1'b0;
      err_ovr_r   <= 1'b0;
    end else begin
      if (line_done_s && !(upd_valid_r && !i_upd_ready)) begin
        upd_valid_r <= 1'b1;
        upd_line_r  <= line_r;
      end else if (i_upd_ready) begin
        upd_valid_r <= 1'b0;
      end
      clr_req_r <= clr_set_s | (clr_req_r & ~i_clr_ack);
      if (disp_on_s) begin
        disp_en_r <= 1'b1;
      end else if (disp_off_s) begin
        disp_en_r <= 1'b0;
      end
      err_cmd_r <= cmd_err_s | (err_cmd_r & ~i_err_clr);
      err_ovr_r <= (line_done_s & upd_valid_r & ~i_upd_ready) | (err_ovr_r & ~i_err_clr);
    end
  end

  assign o_fb_we     = fb_we_r;
  assign o_fb_addr   = fb_addr_r;
  assign o_fb_data   = fb_data_r;
  assign o_upd_valid = upd_valid_r;
  assign o_upd_line  = upd_line_r;
  assign o_clr_req   = clr_req_r;
  assign o_disp_en   = disp_en_r;
  assign o_err_cmd   = err_cmd_r;
  assign o_err_ovr   = err_ovr_r;

endmodule
